frame_stream_tx: RTL

Transmit-side sequencer for the frame-slide convolution input stream. On a start request it reads one 3x3 kernel (9 words) and an N x N single-channel image from a synchronous-read buffer. It drives them onto the 64-bit stream as one control word, 9 weight words, then N² pixel words on consecutive cycles. It then holds the bus idle until the convolution side reports done. It sits between the host-loaded feature buffer and the frame-slide/conv-accelerator input, replacing software pixel-by-pixel writes.

---
 rtl/frame_stream_tx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/frame_stream_tx.sv
// Transmit sequencer: streams one control word, 9 kernel weights and N*N pixels
// from a synchronous-read buffer onto the 64-bit conv input stream.
//
// state  | meaning
// IDLE   | waiting for a start with a legal size
// CTRL   | control word on the bus, first weight read issued
// WGT    | 9 weight words, reads issued one ahead
// PIX    | N*N pixel words placed in the selected 16-bit lane
// WAIT   | bus idle until the convolution side reports done
module frame_stream_tx #(
  parameter int ADDR_W   = 18,
  parameter int WGT_BASE = 0,
  parameter int IMG_BASE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [8:0]        i_img_size,
  input  logic [1:0]        i_img_dim,
  output logic              o_busy,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [63:0]       i_mem_data,
  output logic [63:0]       o_data,
  output logic              o_chip_en,
  input  logic              i_done,
  output logic              o_frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_CTRL, S_WGT, S_PIX, S_WAIT} state_t;

  state_t      state, state_nx;
  logic [8:0]  n_q;
  logic [1:0]  dim_q;
  logic [17:0] cnt_q, cnt_nx;
  logic [17:0] last_q;
  logic [17:0] n_sq;
  logic [63:0] pix_word;
  logic        size_ok;
  logic        accept;

  assign size_ok = (i_img_size >= 9'd3) && (i_img_size <= 9'd416);
  assign accept  = (state == S_IDLE) && i_start && size_ok;
  assign n_sq    = {9'b0, i_img_size} * {9'b0, i_img_size};
  assign o_busy  = (state != S_IDLE);

  // Pixel lands in lane dim; all other bits of the word are forced to zero.
  assign pix_word = {48'b0, i_mem_data[15:0]} << {dim_q, 4'b0000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt_q  <= '0;
      n_q    <= '0;
      dim_q  <= '0;
      last_q <= '0;
    end else begin
      state <= state_nx;
      cnt_q <= cnt_nx;
      if (accept) begin
        n_q    <= i_img_size;
        dim_q  <= i_img_dim;
        last_q <= n_sq - 18'd1;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt_q;
    o_data       = '0;
    o_chip_en    = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_addr   = '0;
    o_frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (accept) state_nx = S_CTRL;
      end
      S_CTRL: begin
        o_data     = {53'b0, n_q, dim_q};
        o_chip_en  = 1'b1;
        o_mem_rd   = 1'b1;
        o_mem_addr = ADDR_W'(WGT_BASE);
        cnt_nx     = '0;
        state_nx   = S_WGT;
      end
      S_WGT: begin
        o_data   = i_mem_data;
        o_mem_rd = 1'b1;
        if (cnt_q == 18'd8) begin
          o_mem_addr = ADDR_W'(IMG_BASE);
          cnt_nx     = '0;
          state_nx   = S_PIX;
        end else begin
          o_mem_addr = ADDR_W'(WGT_BASE) + ADDR_W'(cnt_q) + ADDR_W'(1);
          cnt_nx     = cnt_q + 18'd1;
        end
      end
      S_PIX: begin
        o_data = pix_word;
        if (cnt_q == last_q) begin
          cnt_nx   = '0;
          state_nx = S_WAIT;
        end else begin
          o_mem_rd   = 1'b1;
          o_mem_addr = ADDR_W'(IMG_BASE) + ADDR_W'(cnt_q) + ADDR_W'(1);
          cnt_nx     = cnt_q + 18'd1;
        end
      end
      S_WAIT: begin
        // Done pulse shares the acceptance cycle; busy drops with the IDLE entry.
        if (i_done) begin
          o_frame_done = 1'b1;
          state_nx     = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
